// File: rtl/avst_mon_pkg.sv
// Shared types and constants for the Avalon-ST packet monitor.
//   DATA_W / EMPTY_W / SYMBOLS_PER_BEAT : beat geometry (32-bit, 4 bytes per beat)
//   frame_state_t                       : framing FSM states
//   beat_t                              : one beat plus its sideband, as carried through the skid buffer
//   beat_bytes()                        : number of valid bytes a forwarded beat contributes
package avst_mon_pkg;

    localparam int DATA_W           = 32;
    localparam int EMPTY_W          = 2;
    localparam int SYMBOLS_PER_BEAT = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               error;
    } beat_t;

    // Only the EOP beat may be partially filled; empty counts the unused symbols.
    function automatic logic [2:0] beat_bytes(input logic eop, input logic [EMPTY_W-1:0] empty);
        if (eop) begin
            return 3'(SYMBOLS_PER_BEAT) - 3'(empty);
        end
        return 3'(SYMBOLS_PER_BEAT);
    endfunction

endpackage

// File: rtl/avst_skid_buf.sv
// Two-entry skid buffer for Avalon-ST beats (ready latency 0 on the source side).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_beat  : beat to store (already qualified by the caller's handshake)
//   in_ready            : registered; low exactly while the skid entry is occupied
//   out_valid / out_beat: output register, held stable until out_ready
//   out_ready           : downstream ready
module avst_skid_buf
    import avst_mon_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_ready,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready
);

    logic  skid_valid_p1;
    beat_t skid_beat_p1;

    logic  out_valid_d;
    beat_t out_beat_d;
    logic  skid_valid_d;
    beat_t skid_beat_d;

    always_comb begin
        out_valid_d  = out_valid;
        out_beat_d   = out_beat;
        skid_valid_d = skid_valid_p1;
        skid_beat_d  = skid_beat_p1;
        if (skid_valid_p1) begin
            // Skid occupied implies the output register is full and in_ready is low.
            if (out_ready) begin
                out_beat_d   = skid_beat_p1;
                skid_valid_d = 1'b0;
            end
        end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
                out_valid_d = 1'b1;
                out_beat_d  = in_beat;
            end else begin
                skid_valid_d = 1'b1;
                skid_beat_d  = in_beat;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output / skid stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_beat      <= '0;
            skid_valid_p1 <= 1'b0;
            skid_beat_p1  <= '0;
            in_ready      <= 1'b0;
        end else begin
            out_valid     <= out_valid_d;
            out_beat      <= out_beat_d;
            skid_valid_p1 <= skid_valid_d;
            skid_beat_p1  <= skid_beat_d;
            // Registered ready: mirrors the skid state that takes effect this edge.
            in_ready      <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/avst_pkt_monitor.sv
// Avalon-ST packet monitor / forwarder.
// Checks SOP/EOP framing, drops beats outside a packet, forwards the rest through
// a two-entry skid buffer and keeps saturating statistics counters.
//   clk_clk, reset_reset_n         : clock, asynchronous active-low reset
//   in_*                           : Avalon-ST sink (data, valid, ready, sop, eop, empty, error)
//   out_*                          : Avalon-ST source, same sideband, ready latency 0
//   clear_stats                    : one-cycle synchronous clear of all counters
//   pkt_count / byte_count         : forwarded packets / forwarded bytes
//   err_pkt_count                  : forwarded packets ending with error set
//   frame_err_count                : orphan beats plus missing-EOP violations
module avst_pkt_monitor
    import avst_mon_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int BYTE_CNT_W = 40
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic [EMPTY_W-1:0]    in_empty,
    input  logic                  in_error,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [EMPTY_W-1:0]    out_empty,
    output logic                  out_error,
    input  logic                  clear_stats,
    output logic [CNT_W-1:0]      pkt_count,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0]      err_pkt_count,
    output logic [CNT_W-1:0]      frame_err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base, input logic inc);
        if (inc && (&base)) begin
            return base;
        end
        return base + CNT_W'(inc);
    endfunction

    function automatic logic [BYTE_CNT_W-1:0] sat_add_bytes(input logic [BYTE_CNT_W-1:0] base,
                                                            input logic [2:0]            add);
        logic [BYTE_CNT_W:0] sum;
        sum = {1'b0, base} + (BYTE_CNT_W+1)'(add);
        if (sum[BYTE_CNT_W]) begin
            return '1;
        end
        return sum[BYTE_CNT_W-1:0];
    endfunction

    frame_state_t state_p0;
    frame_state_t state_d;

    beat_t in_beat;
    beat_t out_beat;

    logic       accept;
    logic       fwd;
    logic       frame_err;
    logic       pkt_end;
    logic [2:0] bytes_add;

    logic [CNT_W-1:0]      pkt_cnt_p1;
    logic [BYTE_CNT_W-1:0] byte_cnt_p1;
    logic [CNT_W-1:0]      err_pkt_cnt_p1;
    logic [CNT_W-1:0]      frame_err_cnt_p1;

    assign in_beat = '{data: in_data, sop: in_startofpacket, eop: in_endofpacket,
                       empty: in_empty, error: in_error};

    assign accept = in_valid && in_ready;

    always_comb begin
        fwd       = 1'b0;
        frame_err = 1'b0;
        state_d   = state_p0;
        if (accept) begin
            // An SOP always starts a packet, even when the previous one never ended.
            fwd = in_startofpacket || (state_p0 == ST_IN_PKT);
            frame_err = (state_p0 == ST_IDLE && !in_startofpacket) ||
                        (state_p0 == ST_IN_PKT && in_startofpacket);
            state_d = (fwd && !in_endofpacket) ? ST_IN_PKT : ST_IDLE;
        end
        pkt_end   = fwd && in_endofpacket;
        bytes_add = fwd ? beat_bytes(in_endofpacket, in_empty) : 3'd0;
    end

    // Acceptance stage: framing state and statistics
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_p0         <= ST_IDLE;
            pkt_cnt_p1       <= '0;
            byte_cnt_p1      <= '0;
            err_pkt_cnt_p1   <= '0;
            frame_err_cnt_p1 <= '0;
        end else begin
            state_p0         <= state_d;
            // A clear restarts from zero but still keeps this cycle's increment.
            pkt_cnt_p1       <= sat_inc(clear_stats ? '0 : pkt_cnt_p1, pkt_end);
            byte_cnt_p1      <= sat_add_bytes(clear_stats ? '0 : byte_cnt_p1, bytes_add);
            err_pkt_cnt_p1   <= sat_inc(clear_stats ? '0 : err_pkt_cnt_p1, pkt_end && in_error);
            frame_err_cnt_p1 <= sat_inc(clear_stats ? '0 : frame_err_cnt_p1, frame_err);
        end
    end

    assign pkt_count       = pkt_cnt_p1;
    assign byte_count      = byte_cnt_p1;
    assign err_pkt_count   = err_pkt_cnt_p1;
    assign frame_err_count = frame_err_cnt_p1;

    avst_skid_buf u_skid (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .in_valid  (fwd),
        .in_beat   (in_beat),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_beat  (out_beat),
        .out_ready (out_ready)
    );

    assign out_data          = out_beat.data;
    assign out_startofpacket = out_beat.sop;
    assign out_endofpacket   = out_beat.eop;
    assign out_empty         = out_beat.empty;
    assign out_error         = out_beat.error;

endmodule

// File: tb/tb_avst_pkt_monitor.sv
module tb_avst_pkt_monitor;

    localparam longint unsigned CMAX = 64'hFFFF_FFFF;
    localparam longint unsigned BMAX = 64'hFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_empty;
    logic        in_error;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        out_error;
    logic        clear_stats;
    logic [31:0] pkt_count;
    logic [39:0] byte_count;
    logic [31:0] err_pkt_count;
    logic [31:0] frame_err_count;

    always #5 clk = ~clk;

    avst_pkt_monitor dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .in_error          (in_error),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
        .out_error         (out_error),
        .clear_stats       (clear_stats),
        .pkt_count         (pkt_count),
        .byte_count        (byte_count),
        .err_pkt_count     (err_pkt_count),
        .frame_err_count   (frame_err_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: expected output beats {data,sop,eop,empty,error} and counter values.
    logic [36:0]     exp_q[$];
    bit              m_in_pkt;
    longint unsigned m_pkt, m_byte, m_err, m_frm;
    bit              last_acc;
    int              n_out;
    bit              toggle_mode;
    bit              rand_ready;
    bit              saw_stall;

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_pkt = 0; m_byte = 0; m_err = 0; m_frm = 0;
    endtask

    // One clock: check at the falling edge, update the model for the handshakes
    // that the next rising edge will complete, then advance past that edge.
    task automatic step();
        logic [36:0] got;
        logic [36:0] want;
        bit          fwd;
        @(negedge clk);
        chk("pkt_count", 64'(pkt_count), m_pkt);
        chk("byte_count", 64'(byte_count), m_byte);
        chk("err_pkt_count", 64'(err_pkt_count), m_err);
        chk("frame_err_count", 64'(frame_err_count), m_frm);
        if (rst_n && !in_ready) saw_stall = 1'b1;
        last_acc = 1'b0;
        if (out_valid && out_ready) begin
            got = {out_data, out_sop, out_eop, out_empty, out_error};
            n_out++;
            if (exp_q.size() == 0) begin
                chk("out_extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                want = exp_q.pop_front();
                chk("out_beat", 64'(got), 64'(want));
            end
        end
        if (rst_n) begin
            if (clear_stats) begin
                m_pkt = 0; m_byte = 0; m_err = 0; m_frm = 0;
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                fwd = in_sop || m_in_pkt;
                if (in_sop == m_in_pkt) m_frm = sat(m_frm + 1, CMAX);
                if (fwd) begin
                    exp_q.push_back({in_data, in_sop, in_eop, in_empty, in_error});
                    if (in_eop) begin
                        m_pkt  = sat(m_pkt + 1, CMAX);
                        m_byte = sat(m_byte + 4 - longint'(in_empty), BMAX);
                        if (in_error) m_err = sat(m_err + 1, CMAX);
                    end else begin
                        m_byte = sat(m_byte + 4, BMAX);
                    end
                end
                m_in_pkt = fwd && !in_eop;
            end
        end
        @(posedge clk);
        #1;
        if (toggle_mode) out_ready = ~out_ready;
        else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] d, input logic sop, input logic eop,
                        input logic [1:0] empty, input logic err);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = empty;
        in_error = err;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid    = 1'b0;
        toggle_mode = 1'b0;
        rand_ready  = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = '0; in_error = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
        toggle_mode = 1'b0; rand_ready = 1'b0; saw_stall = 1'b0; n_out = 0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_side", 64'({out_data, out_sop, out_eop, out_empty, out_error}), 64'd0);
        rst_n = 1'b1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        step();
        chk("in_ready_after_edge", 64'(in_ready), 64'd1);

        // 3-beat packet
        n0 = n_out;
        send(32'hA0A0_0001, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        send(32'hA0A0_0002, 1'b0, 1'b0, 2'd0, 1'b0);
        send(32'hA0A0_0003, 1'b0, 1'b1, 2'd1, 1'b0);
        drain();
        chk("t1_beats", 64'(n_out - n0), 64'd3);
        chk("t1_pkt", 64'(pkt_count), 64'd1);
        chk("t1_bytes", 64'(byte_count), 64'd11);
        chk("t1_err", 64'(err_pkt_count), 64'd0);

        // Single-beat errored packet
        pulse_clear();
        send(32'hB1B1_B1B1, 1'b1, 1'b1, 2'd3, 1'b1);
        drain();
        chk("t2_pkt", 64'(pkt_count), 64'd1);
        chk("t2_bytes", 64'(byte_count), 64'd1);
        chk("t2_err", 64'(err_pkt_count), 64'd1);

        // Orphans then a 2-beat packet
        pulse_clear();
        n0 = n_out;
        send(32'hDEAD_0001, 1'b0, 1'b0, 2'd0, 1'b0);
        send(32'hDEAD_0002, 1'b0, 1'b1, 2'd0, 1'b0);
        send(32'hC0C0_0001, 1'b1, 1'b0, 2'd0, 1'b0);
        send(32'hC0C0_0002, 1'b0, 1'b1, 2'd0, 1'b0);
        drain();
        chk("t3_frame_err", 64'(frame_err_count), 64'd2);
        chk("t3_beats", 64'(n_out - n0), 64'd2);
        chk("t3_bytes", 64'(byte_count), 64'd8);

        // Missing EOP: SOP, mid, SOP, EOP
        pulse_clear();
        n0 = n_out;
        send(32'hD0D0_0001, 1'b1, 1'b0, 2'd0, 1'b0);
        send(32'hD0D0_0002, 1'b0, 1'b0, 2'd0, 1'b0);
        send(32'hD0D0_0003, 1'b1, 1'b0, 2'd0, 1'b0);
        send(32'hD0D0_0004, 1'b0, 1'b1, 2'd0, 1'b0);
        drain();
        chk("t4_beats", 64'(n_out - n0), 64'd4);
        chk("t4_frame_err", 64'(frame_err_count), 64'd1);
        chk("t4_pkt", 64'(pkt_count), 64'd1);

        // 8-beat packet with out_ready toggling every cycle
        pulse_clear();
        n0 = n_out;
        saw_stall = 1'b0;
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++)
            send($urandom(), (i == 0), (i == 7), 2'd0, 1'b0);
        drain();
        chk("t5_stall_seen", 64'(saw_stall), 64'd1);
        chk("t5_beats", 64'(n_out - n0), 64'd8);
        chk("t5_bytes", 64'(byte_count), 64'd32);

        // Saturation and clear priority on err_pkt_count
        pulse_clear();
        force dut.err_pkt_cnt_p1 = 32'hFFFF_FFFF;
        m_err = CMAX;
        step();
        release dut.err_pkt_cnt_p1;
        chk("t6_forced", 64'(err_pkt_count), CMAX);
        send(32'hE0E0_0001, 1'b1, 1'b1, 2'd0, 1'b1);
        drain();
        chk("t6_saturated", 64'(err_pkt_count), CMAX);
        send(32'hE0E0_0002, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("t6_before_clear", 64'(err_pkt_count), CMAX);
        clear_stats = 1'b1;
        send(32'hE0E0_0003, 1'b0, 1'b1, 2'd2, 1'b1);
        clear_stats = 1'b0;
        chk("t6_after_clear", 64'(err_pkt_count), 64'd1);
        drain();

        // Randomized traffic against the model
        pulse_clear();
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            clear_stats = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end else begin
                send($urandom(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            clear_stats = 1'b0;
        end
        drain();

        // Reset in the middle of a packet
        out_ready = 1'b0;
        send(32'hF0F0_0001, 1'b1, 1'b0, 2'd0, 1'b0);
        send(32'hF0F0_0002, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_pkt", 64'(pkt_count), 64'd0);
        chk("midrst_bytes", 64'(byte_count), 64'd0);
        model_reset();
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        n0 = n_out;
        send(32'hF0F0_0003, 1'b0, 1'b1, 2'd0, 1'b0);
        drain();
        chk("midrst_orphan_frame_err", 64'(frame_err_count), 64'd1);
        chk("midrst_orphan_dropped", 64'(n_out - n0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avst_pkt_monitor.md
# avst_pkt_monitor

Single-clock Avalon-ST packet monitor and forwarder placed directly downstream of the output side of the dual-clock packet FIFO in the E10 Ethernet loopback path. It accepts 32-bit beats with start/end-of-packet, empty and error sideband, and forwards them through a two-entry skid buffer. Beats outside a packet are dropped. It keeps saturating packet, byte, errored-packet and framing-error counters for CSR readout.

## Interface
- CNT_W, 32, width of pkt_count, err_pkt_count, frame_err_count
- BYTE_CNT_W, 40, width of byte_count
- Clocking (already decided): one clock, clk_clk; reset reset_reset_n is asynchronous and active-low.
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous active-low reset
- in_data  in  32  sink data
- in_valid  in  1  sink valid
- in_ready  out  1  sink ready
- in_startofpacket  in  1  sink SOP
- in_endofpacket  in  1  sink EOP
- in_empty  in  2  empty symbols on the EOP beat
- in_error  in  1  packet error flag on the EOP beat
- out_data  out  32  source data
- out_valid  out  1  source valid
- out_ready  in  1  source ready
- out_startofpacket  out  1  source SOP
- out_endofpacket  out  1  source EOP
- out_empty  out  2  source empty
- out_error  out  1  source error
- clear_stats  in  1  synchronous one-cycle counter clear
- pkt_count  out  CNT_W  completed packets
- byte_count  out  BYTE_CNT_W  bytes of forwarded beats
- err_pkt_count  out  CNT_W  packets whose EOP beat had in_error=1
- frame_err_count  out  CNT_W  framing violations

## Operation
- A beat is accepted when in_valid && in_ready. All framing decisions and counting happen at acceptance.
- Framing FSM states:
  - IDLE (reset state; between packets) and IN_PKT.
  - IDLE + SOP + !EOP: forward the beat, go to IN_PKT.
  - IDLE + SOP + EOP: forward the beat (single-beat packet), stay IDLE.
  - IDLE + !SOP: orphan beat. It is accepted but not forwarded. frame_err_count increments. Stay IDLE.
  - IN_PKT + !SOP + EOP: forward the beat, go to IDLE.
  - IN_PKT + !SOP + !EOP: forward the beat, stay IN_PKT.
  - IN_PKT + SOP: missing-EOP violation. frame_err_count increments. The beat is forwarded unchanged and treated as a new packet start; next state follows its EOP bit as in IDLE.
- Packet counters (forwarded beats only):
  - pkt_count increments on every forwarded EOP beat.
  - err_pkt_count increments on a forwarded EOP beat with in_error=1.
  - in_error and in_empty on non-EOP beats are passed through but do not affect the counters.
- Byte counting (forwarded beats only):
  - A non-EOP beat adds 4.
  - An EOP beat adds 4 − in_empty, i.e. 1..4.
- All counters saturate at all-ones and never wrap.
- clear_stats takes priority over accumulation history: the result is 0 plus the increment of that same cycle.
- Forwarded beats keep their order. The sideband travels unmodified with the data.

## Timing
- Reset values:
  - in_ready = 0; out_valid = 0.
  - out_data, SOP, EOP, empty and error = 0.
  - All counters = 0; FSM = IDLE.
- in_ready rises at the first clk_clk edge after reset_reset_n deasserts.
- Latency: a beat accepted at edge N shows out_valid=1 in the cycle after edge N.
- Throughput: one beat per cycle while out_ready stays high.
- Skid buffer:
  - in_ready is registered and equals !skid_valid.
  - If the output register holds a beat and out_ready=0 while a beat is accepted, that beat goes to the skid register. in_ready then drops on the next cycle.
  - A beat is never lost or duplicated.
- out_valid, once asserted, holds with stable data until out_ready=1 (Avalon-ST ready latency 0).
- Counter outputs update at the edge after acceptance, the same edge the beat becomes visible on the output.
- Reset asserted mid-packet immediately clears everything to reset values. Any in-flight packet is discarded.

## Structure
- Package avst_mon_pkg holds:
  - DATA_W=32, EMPTY_W=2, SYMBOLS_PER_BEAT=4.
  - An enum for the IDLE/IN_PKT states.
  - A packed beat struct {data, sop, eop, empty, error}.
- One sub-module, avst_skid_buf: two-entry beat buffer carrying the struct, with valid/ready on both sides.
- Framing FSM and counters live in the top module.

## Test plan
- Reset, then a 3-beat packet (SOP, mid, EOP with empty=1, error=0) with out_ready=1 → three beats out with 1-cycle latency; pkt_count=1, byte_count=11, err_pkt_count=0.
- Single-beat packet (SOP+EOP, empty=3, error=1) → forwarded; pkt_count=1, byte_count=1, err_pkt_count=1.
- Two non-SOP beats while IDLE, then a valid 2-beat packet → orphans not forwarded; frame_err_count=2; only 2 beats appear on the output; byte_count=8 (empty=0).
- SOP, mid, SOP, EOP → all 4 beats forwarded; frame_err_count=1; pkt_count=1.
- 8-beat packet with out_ready toggling 0/1 every cycle and in_valid=1 → in_ready drops after the skid fills; output order and data are identical to input; no beat lost or duplicated.
- Load err_pkt_count to all-ones (force), then send an errored packet with clear_stats pulsed on its EOP cycle → counter stays all-ones before the clear; after the clear cycle it reads 1.
